// File: rtl/i2s_rx.sv
// I2S slave receiver: deserializes left/right words on mclk and presents one stereo pair per frame.
// Define I2S_RX_SYNC_EN to pass sclk, lrclk and sdata through 2-flop synchronizers first.
module i2s_rx #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned SLOT_WIDTH = 32
) (
  input  logic                  mclk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  lrclk,
  input  logic                  sdata,
  output logic [DATA_WIDTH-1:0] left_data,
  output logic [DATA_WIDTH-1:0] right_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int unsigned CntWidth = $clog2(SLOT_WIDTH + 2);
  localparam logic [CntWidth-1:0] CntData = CntWidth'(DATA_WIDTH);
  localparam logic [CntWidth-1:0] CntSlot = CntWidth'(SLOT_WIDTH);
  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

  localparam logic [1:0] StHunt  = 2'd0;
  localparam logic [1:0] StLeft  = 2'd1;
  localparam logic [1:0] StRight = 2'd2;

  logic sclk_s;
  logic lrclk_s;
  logic sdata_s;

`ifdef I2S_RX_SYNC_EN
  logic [1:0] sclk_sync_q, sclk_sync_d;
  logic [1:0] lrclk_sync_q, lrclk_sync_d;
  logic [1:0] sdata_sync_q, sdata_sync_d;

  always_comb begin
    sclk_sync_d  = {sclk_sync_q[0], sclk};
    lrclk_sync_d = {lrclk_sync_q[0], lrclk};
    sdata_sync_d = {sdata_sync_q[0], sdata};
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      sclk_sync_q  <= '0;
      lrclk_sync_q <= '0;
      sdata_sync_q <= '0;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      lrclk_sync_q <= lrclk_sync_d;
      sdata_sync_q <= sdata_sync_d;
    end
  end

  assign sclk_s  = sclk_sync_q[1];
  assign lrclk_s = lrclk_sync_q[1];
  assign sdata_s = sdata_sync_q[1];
`else
  assign sclk_s  = sclk;
  assign lrclk_s = lrclk;
  assign sdata_s = sdata;
`endif

  logic                  sclk_q, sclk_d;
  logic                  lr_q, lr_d;
  logic [1:0]            state_q, state_d;
  logic [CntWidth-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
  logic [DATA_WIDTH-1:0] left_data_q, left_data_d;
  logic [DATA_WIDTH-1:0] right_data_q, right_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  frame_err_q, frame_err_d;

  logic                  rise;
  logic                  lr_change;
  logic                  word_done;
  logic                  pair_done;
  logic [DATA_WIDTH-1:0] word;

  // Serial side: edge detect, slot tracking and word assembly.
  always_comb begin
    rise      = sclk_s & ~sclk_q;
    lr_change = rise & (lrclk_s ^ lr_q);
    word      = {shift_q[DATA_WIDTH-2:0], sdata_s};

    sclk_d      = sclk_s;
    lr_d        = rise ? lrclk_s : lr_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    left_hold_d = left_hold_q;
    frame_err_d = 1'b0;
    word_done   = 1'b0;

    if (rise) begin
      case (state_q)
        StHunt: begin
          if (lr_change && !lrclk_s) begin
            state_d   = StLeft;
            bit_cnt_d = '0;
            shift_d   = '0;
          end
        end
        StLeft, StRight: begin
          if (lr_change) begin
            // This rise is the delay bit of the new slot; judge the slot that just ended.
            bit_cnt_d = '0;
            shift_d   = '0;
            if (bit_cnt_q < CntData) begin
              frame_err_d = 1'b1;
              state_d     = StHunt;
            end else begin
              state_d = (state_q == StLeft) ? StRight : StLeft;
            end
          end else if (bit_cnt_q >= CntSlot) begin
            frame_err_d = 1'b1;
            state_d     = StHunt;
          end else begin
            bit_cnt_d = bit_cnt_q + CntOne;
            if (bit_cnt_q < CntData) begin
              shift_d   = word;
              word_done = (bit_cnt_q == CntData - CntOne);
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end

    if (word_done && state_q == StLeft) begin
      left_hold_d = word;
    end
  end

  assign pair_done = word_done && (state_q == StRight);

  // Parallel side: output registers and valid/ready handshake.
  always_comb begin
    left_data_d  = left_data_q;
    right_data_d = right_data_q;
    out_valid_d  = out_valid_q;
    overrun_d    = 1'b0;

    if (pair_done) begin
      left_data_d  = left_hold_q;
      right_data_d = word;
      out_valid_d  = 1'b1;
      // Completing in the acceptance cycle is a clean handoff, not an overrun.
      overrun_d    = out_valid_q & ~out_ready;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      sclk_q       <= 1'b0;
      lr_q         <= 1'b0;
      state_q      <= StHunt;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      left_hold_q  <= '0;
      left_data_q  <= '0;
      right_data_q <= '0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sclk_q       <= sclk_d;
      lr_q         <= lr_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      left_hold_q  <= left_hold_d;
      left_data_q  <= left_data_d;
      right_data_q <= right_data_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign left_data  = left_data_q;
  assign right_data = right_data_q;
  assign out_valid  = out_valid_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S receiver (slave deserializer) for the ADC path. Runs entirely on mclk and consumes the sclk/lrclk generated by the pedal's I2S clock divider.
- Samples serial ADC data and assembles left and right words, MSB first, with the standard 1-bit I2S delay.
- Presents one stereo sample per frame to the DSP chain over a valid/ready handshake.

Parameters:
- DATA_WIDTH, 24, captured bits per channel (MSB first); must be <= SLOT_WIDTH-1.
- SLOT_WIDTH, 32, sclk periods per lrclk half-period; used only for error checking.

Ports:
- mclk  input  1  system/master clock; all logic on rising edge
- rst  input  1  synchronous reset, active-high
- sclk  input  1  bit clock, mclk-synchronous level (period 8 mclk with the standard divider)
- lrclk  input  1  word select: 0 = left, 1 = right; changes on sclk falling edge
- sdata  input  1  serial data from ADC, stable around sclk rising edge
- left_data  output  DATA_WIDTH  left sample of last complete frame
- right_data  output  DATA_WIDTH  right sample of last complete frame
- out_valid  output  1  stereo pair available
- out_ready  input  1  consumer accepts pair when out_valid && out_ready
- overrun  output  1  one-cycle pulse: new frame completed while previous pair unaccepted
- frame_err  output  1  one-cycle pulse: lrclk changed before DATA_WIDTH bits captured, or slot exceeded SLOT_WIDTH rises

Behaviour:
- Reset values: left_data = 0, right_data = 0, out_valid = 0, overrun = 0, frame_err = 0. Internal: shift reg 0, bit_cnt 0, sclk_q 0, lr_q 0, state HUNT.
- Edge detect: sclk_q <= sclk every mclk. rise = sclk & ~sclk_q. All serial actions occur only in rise cycles. sdata and lrclk are sampled in the rise cycle.
- lr_change = (lrclk != lr_q) in a rise cycle. lr_q updates on every rise.
- FSM:
  - HUNT: ignore data. On a rise with lr_change and lrclk == 0 -> LEFT with bit_cnt = 0. The first frame after reset is therefore dropped until a right-to-left transition is seen.
  - LEFT / RIGHT: the rise with lr_change is the delay slot. bit_cnt = 0 and no capture. On subsequent rises bit_cnt increments.
    - For bit_cnt 1..DATA_WIDTH, shift sdata in MSB first.
    - Rises beyond DATA_WIDTH are ignored padding.
  - On lr_change in LEFT: if fewer than DATA_WIDTH bits were captured -> pulse frame_err, go to HUNT. Otherwise switch to RIGHT.
  - On lr_change in RIGHT: same check, then switch to LEFT.
- Word completion: in the rise cycle where bit DATA_WIDTH is shifted in:
  - LEFT: the word goes to an internal left_hold register.
  - RIGHT: on the next mclk edge, left_data <= left_hold, right_data <= completed word, out_valid <= 1.
- Latency: out_valid asserts on the mclk edge ending the rise cycle of the right channel's LSB. With the standard divider this is 197 mclk after the lrclk rise, counted from its register edge.
- Handshake:
  - out_valid stays high and data stays stable until the cycle out_valid && out_ready, then out_valid drops on the next edge.
  - If a new pair completes in the same cycle as acceptance, out_valid stays 1 with the new data and there is no overrun.
  - If a new pair completes while out_valid = 1 and out_ready = 0: data is overwritten with the new pair, out_valid stays 1, and overrun pulses for 1 cycle.
- Slot overflow: if bit_cnt would exceed SLOT_WIDTH without lr_change -> pulse frame_err, go to HUNT. bit_cnt saturates and never wraps.
- rst mid-word: everything returns to reset values immediately and any partial word is discarded.
- frame_err and overrun can pulse in the same cycle.

Optional Feature:
- Macro: I2S_RX_SYNC_EN.
- Defined: sclk, lrclk and sdata each pass through a 2-flop synchronizer (reset to 0) before edge detection. This allows an external master clock source. All latencies grow by 2 mclk, and function is otherwise identical.
- Undefined: inputs are used directly, as specified above.

Test Plan:
- Divider-model clocks, left=0xA5A5A5, right=0x5A5A5A, padding 0s, out_ready=1 -> after the first right-to-left sync, out_valid pulses 1 cycle per frame (every 512 mclk) with left_data=0xA5A5A5, right_data=0x5A5A5A; frame_err=0, overrun=0.
- MSB/delay check: left=0x800001, padding bits set to 1 -> left_data=0x800001 exactly. This proves the delay-slot bit is skipped and padding is ignored.
- out_ready held 0 for 2 frames (second frame 0x123456/0x654321) -> overrun pulses once at the second completion, out_valid stays 1, data=0x123456/0x654321. Raise out_ready -> out_valid drops next cycle.
- Short slot: force lrclk to toggle after 10 rises in a left slot -> frame_err pulses 1 cycle, no out_valid for that frame, recovery and valid data from the next full frame.
- rst asserted for 1 cycle mid-right-word -> all outputs 0 next cycle. The first frame after reset is dropped, and the next frame outputs correctly.
- With I2S_RX_SYNC_EN defined, repeat scenario 1 -> identical data, with out_valid 2 mclk later than the undefined build.
